fifo_subword_read: RTL
======================

// Module: fifo_subword_read
// PURPOSE
//  FIFO that takes full-width words on the write side and returns 1..LANES sub-word lanes per read.
//  Generalises the half-width-read FIFO to any lane count.
//  Consumer-side buffer for stream parsers that take variable-size tokens from a packed word stream.
//  First-word-fallthrough. Oldest unread lane is always presented at dataout lane 0.
// PARAMETERS
//  LANE_WIDTH          4   bits per lane
//  LANES               4   lanes per word (>=2); WIDTH = LANES*LANE_WIDTH
//  DEPTH               8   storage in words (power of two, >=2)
//  TRIGGERALMOSTFULL   1   almostFull asserts when count >= DEPTH-TRIGGERALMOSTFULL
//  TRIGGERALMOSTEMPTY  1   almostEmpty asserts when count <= TRIGGERALMOSTEMPTY
// PORTS
//  clk          in   1                 clock; all state on rising edge
//  reset        in   1                 asynchronous, active-low reset
//  flush        in   1                 synchronous clear of contents
//  write        in   1                 push datain this cycle
//  datain       in   WIDTH             word to push; lane 0 = bits [LANE_WIDTH-1:0]
//  full         out  1                 count == DEPTH
//  almostFull   out  1                 see TRIGGERALMOSTFULL
//  read         in   1                 consume readLanes lanes this cycle
//  readLanes    in   $clog2(LANES+1)   number of lanes to consume
//  dataout      out  WIDTH             head word shifted right by offset*LANE_WIDTH; vacated upper lanes are 0
//  valid        out  1                 head word present (count != 0)
//  lanesAvail   out  $clog2(LANES+1)   LANES-offset when valid, else 0
//  empty        out  1                 count == 0
//  almostEmpty  out  1                 see TRIGGERALMOSTEMPTY
//  count        out  $clog2(DEPTH+1)   words held, including a partially consumed head
// BEHAVIOUR
//  - Reset (reset low, async): pointers, offset and count = 0; dataout = 0; valid = 0; lanesAvail = 0.
//    empty = 1, almostEmpty = 1, full = 0, almostFull = 0. Reset may assert at any cycle; any partial head is lost.
//  - flush=1: same end state as reset, applied at the clock edge. Overrides write/read in the same cycle.
//  - Write: accepted iff write & !full. A write while full is dropped; no state change, no error flag.
//    A write while full is dropped even if the same cycle pops a word.
//  - Fallthrough: a word written into an empty FIFO shows on dataout with valid=1 the next cycle (latency 1).
//  - Read: acted on iff read & valid & readLanes != 0; otherwise ignored.
//    k = min(readLanes, lanesAvail).
//    k < lanesAvail: offset += k; count unchanged.
//    k == lanesAvail: head word popped; offset = 0; next word presented at the following edge.
//    Values above lanesAvail (including values above LANES) are clamped. A partial read never spans two words.
//  - Simultaneous accepted write and pop: count unchanged. Write and partial read: count +1.
//  - Pointers wrap modulo DEPTH. count saturates by construction (0..DEPTH).
//  - All status outputs are combinational from registered count/offset; no read-to-status bypass.
//  - dataout is combinational from memory[rdPtr] and offset. It is 0 when valid=0.
// TESTING  (LANE_WIDTH=4, LANES=4, DEPTH=8, triggers=1)
//  1. Write 0xA5C3 to empty -> next cycle valid=1, dataout=0xA5C3, lanesAvail=4.
//     read k=1 -> dataout=0x0A5C, lanesAvail=3. read k=3 -> empty=1, dataout=0.
//  2. Write 8 words -> almostFull after the 7th, full after the 8th.
//     9th write dropped: count=8, and the drained data are the 8 originals in order.
//  3. Fresh head 0x1234, read k=7 -> clamped to 4. Word popped, next word at lane 0, offset=0.
//  4. count=1, head partially read (offset=2); write + read k=2 same cycle -> count=1, new word at dataout, lanesAvail=4.
//  5. flush with offset=3, count=5, plus write=1 the same cycle -> count=0, empty=1, write discarded.
//     Assert reset mid-stream between edges -> outputs reach reset values immediately, before the next clock edge.
//  6. 40 random write/read(k=1..4) cycles crossing pointer wrap -> lane stream matches a reference queue; count never exceeds 8.

Source files
------------

// File: rtl/fifo_subword_read.sv
// Word-wide write, lane-granular read FIFO with first-word fallthrough.
// The oldest unread lane always appears at dataout lane 0; a read consumes 1..LANES lanes of the head word.
module fifo_subword_read #(
    parameter int LANE_WIDTH         = 4,
    parameter int LANES              = 4,
    parameter int DEPTH              = 8,
    parameter int TRIGGERALMOSTFULL  = 1,
    parameter int TRIGGERALMOSTEMPTY = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           write,
    input  logic [LANES*LANE_WIDTH-1:0]    datain,
    output logic                           full,
    output logic                           almostFull,
    input  logic                           read,
    input  logic [$clog2(LANES+1)-1:0]     readLanes,
    output logic [LANES*LANE_WIDTH-1:0]    dataout,
    output logic                           valid,
    output logic [$clog2(LANES+1)-1:0]     lanesAvail,
    output logic                           empty,
    output logic                           almostEmpty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int WIDTH = LANES * LANE_WIDTH;
    localparam int LW    = $clog2(LANES + 1);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam int OW    = $clog2(LANES);
    localparam int SW    = $clog2(WIDTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    offset_q, offset_d;
    logic [CW-1:0]    count_q, count_d;

    logic             wr_acc;
    logic             rd_act;
    logic             pop;
    logic [LW-1:0]    avail;
    logic [LW-1:0]    take;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] head;

    // Status is derived only from registered count/offset, never from this cycle's read.
    assign valid       = (count_q != '0);
    assign empty       = !valid;
    assign full        = (count_q == CW'(DEPTH));
    assign almostFull  = int'(count_q) >= (DEPTH - TRIGGERALMOSTFULL);
    assign almostEmpty = int'(count_q) <= TRIGGERALMOSTEMPTY;
    assign count       = count_q;
    assign avail       = valid ? (LW'(LANES) - LW'(offset_q)) : '0;
    assign lanesAvail  = avail;

    assign head    = mem_q[rd_ptr_q];
    assign shamt   = SW'(offset_q) * SW'(LANE_WIDTH);
    assign dataout = valid ? (head >> shamt) : '0;

    always_comb begin
        wr_acc   = write && !full;
        rd_act   = read && valid && (readLanes != '0);
        take     = (readLanes > avail) ? avail : readLanes;
        pop      = rd_act && (take == avail);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        offset_d = offset_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            offset_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc)
                wr_ptr_d = wr_ptr_q + 1'b1;
            // A partial read stays inside the head word; only a full drain advances rd_ptr.
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                offset_d = '0;
            end else if (rd_act) begin
                offset_d = offset_q + OW'(take);
            end
            count_d = count_q + CW'(wr_acc) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            offset_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            offset_q <= offset_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: dataout is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush)
            mem_q[wr_ptr_q] <= datain;
    end

endmodule
